// File: rtl/jelly_axi4s_remove_control_signal.sv
`default_nettype none
// ============================================================================
//  Module   : jelly_axi4s_remove_control_signal
//  Purpose  : Strips tuser/tlast from an AXI4-Stream video stream and emits
//             raw tdata. Locks onto start-of-frame, discards pre-SOF beats,
//             tracks x/y against the sampled width/height and flags framing
//             errors with single-cycle pulses aligned to the offending beat.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    aclk, aresetn, aclken          clock, async active-low reset, clock enable
//    param_width / param_height     expected geometry, sampled on SOF accept
//    s_axi4s_tuser/tlast/tdata/
//      tvalid/tready                slave video stream (tuser[0]=SOF, tlast=EOL)
//    m_axi4s_tdata/tvalid/tready    master raw pixel stream (1-cycle latency)
//    frame_start, frame_end         frame boundary pulses
//    err_sof, err_eol               framing error pulses
// ============================================================================
module jelly_axi4s_remove_control_signal #(
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 10,
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 24
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   aclken,

    input  logic [X_WIDTH-1:0]     param_width,
    input  logic [Y_WIDTH-1:0]     param_height,

    input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
    input  logic                   s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                   s_axi4s_tvalid,
    output logic                   s_axi4s_tready,

    output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                   m_axi4s_tvalid,
    input  logic                   m_axi4s_tready,

    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   err_sof,
    output logic                   err_eol
);

    localparam logic [X_WIDTH-1:0] c_x_one = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] c_y_one = Y_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t                 r_state;
    logic [X_WIDTH-1:0]     r_x;
    logic [Y_WIDTH-1:0]     r_y;
    logic [X_WIDTH-1:0]     r_width;
    logic [Y_WIDTH-1:0]     r_height;
    logic                   r_m_tvalid;
    logic [TDATA_WIDTH-1:0] r_m_tdata;
    logic                   r_frame_start;
    logic                   r_frame_end;
    logic                   r_err_sof;
    logic                   r_err_eol;

    logic                   w_out_ready;
    logic                   w_accept;
    logic                   w_sof;
    logic                   w_take;
    logic [X_WIDTH-1:0]     w_cur_x;
    logic [Y_WIDTH-1:0]     w_cur_y;
    logic [X_WIDTH-1:0]     w_cur_w;
    logic [Y_WIDTH-1:0]     w_cur_h;
    logic                   w_x_end;
    logic                   w_x_short;
    logic                   w_y_end;
    logic                   w_frame_done;
    logic                   w_eol_err;
    logic [X_WIDTH-1:0]     w_next_x;
    logic [Y_WIDTH-1:0]     w_next_y;
    logic                   w_unused_tuser;

    // Only the SOF bit of tuser carries meaning here.
    assign w_unused_tuser = ^s_axi4s_tuser;

    assign w_out_ready    = !r_m_tvalid || m_axi4s_tready;
    assign s_axi4s_tready = w_out_ready;
    assign w_accept       = aclken && s_axi4s_tvalid && w_out_ready;
    assign w_sof          = s_axi4s_tuser[0];

    always_comb begin
        // An SOF beat is always evaluated as pixel (0,0) of a freshly
        // latched geometry, whether it arrives in WAIT_SOF or mid-frame.
        w_cur_x = r_x;
        w_cur_y = r_y;
        w_cur_w = r_width;
        w_cur_h = r_height;
        if (w_sof) begin
            w_cur_x = '0;
            w_cur_y = '0;
            w_cur_w = param_width;
            w_cur_h = param_height;
        end

        w_take       = w_accept && (w_sof || (r_state == ST_RUN));
        w_x_end      = (w_cur_x == (w_cur_w - c_x_one));
        w_x_short    = (w_cur_x <  (w_cur_w - c_x_one));
        w_y_end      = (w_cur_y == (w_cur_h - c_y_one));
        w_frame_done = s_axi4s_tlast && w_y_end;

        // Short line is flagged on its tlast; a long line is flagged once,
        // on the beat that should have carried tlast, and not again when
        // its late tlast finally shows up.
        w_eol_err = s_axi4s_tlast ? w_x_short : w_x_end;

        if (s_axi4s_tlast) begin
            w_next_x = '0;
        end else if (&w_cur_x) begin
            w_next_x = w_cur_x;
        end else begin
            w_next_x = w_cur_x + c_x_one;
        end

        if (!s_axi4s_tlast) begin
            w_next_y = w_cur_y;
        end else if (w_y_end) begin
            w_next_y = '0;
        end else begin
            w_next_y = w_cur_y + c_y_one;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ST_WAIT_SOF;
            r_x           <= '0;
            r_y           <= '0;
            r_width       <= '0;
            r_height      <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tdata     <= '0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_err_sof     <= 1'b0;
            r_err_eol     <= 1'b0;
        end else if (aclken) begin
            // Pulses describe the beat accepted this cycle and clear on the
            // next enabled cycle, independent of downstream back-pressure.
            r_frame_start <= w_take && w_sof;
            r_frame_end   <= w_take && w_frame_done;
            r_err_sof     <= w_take && w_sof && (r_state == ST_RUN);
            r_err_eol     <= w_take && w_eol_err;

            if (w_out_ready) begin
                r_m_tvalid <= w_take;
                r_m_tdata  <= s_axi4s_tdata;
            end

            if (w_take) begin
                r_x     <= w_next_x;
                r_y     <= w_next_y;
                r_state <= w_frame_done ? ST_WAIT_SOF : ST_RUN;
                if (w_sof) begin
                    r_width  <= param_width;
                    r_height <= param_height;
                end
            end
        end
    end

    assign m_axi4s_tvalid = r_m_tvalid;
    assign m_axi4s_tdata  = r_m_tdata;
    assign frame_start    = r_frame_start;
    assign frame_end      = r_frame_end;
    assign err_sof        = r_err_sof;
    assign err_eol        = r_err_eol;

endmodule
`default_nettype wire

// File: tb/tb_jelly_axi4s_remove_control_signal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jelly_axi4s_remove_control_signal
//  Purpose  : Self-checking bench for jelly_axi4s_remove_control_signal.
//             Beat tables carry hand-derived expected forwarding and pulse
//             values; forwarded data is queued on acceptance and compared
//             when the master port completes a transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jelly_axi4s_remove_control_signal;

    logic        aclk;
    logic        aresetn;
    logic        aclken;
    logic [9:0]  param_width;
    logic [9:0]  param_height;
    logic [0:0]  s_axi4s_tuser;
    logic        s_axi4s_tlast;
    logic [23:0] s_axi4s_tdata;
    logic        s_axi4s_tvalid;
    logic        s_axi4s_tready;
    logic [23:0] m_axi4s_tdata;
    logic        m_axi4s_tvalid;
    logic        m_axi4s_tready;
    logic        frame_start;
    logic        frame_end;
    logic        err_sof;
    logic        err_eol;

    jelly_axi4s_remove_control_signal #(
        .X_WIDTH     (10),
        .Y_WIDTH     (10),
        .TUSER_WIDTH (1),
        .TDATA_WIDTH (24)
    ) u_dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .aclken         (aclken),
        .param_width    (param_width),
        .param_height   (param_height),
        .s_axi4s_tuser  (s_axi4s_tuser),
        .s_axi4s_tlast  (s_axi4s_tlast),
        .s_axi4s_tdata  (s_axi4s_tdata),
        .s_axi4s_tvalid (s_axi4s_tvalid),
        .s_axi4s_tready (s_axi4s_tready),
        .m_axi4s_tdata  (m_axi4s_tdata),
        .m_axi4s_tvalid (m_axi4s_tvalid),
        .m_axi4s_tready (m_axi4s_tready),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .err_sof        (err_sof),
        .err_eol        (err_eol)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // pulses = {frame_start, frame_end, err_sof, err_eol}
    typedef struct {
        logic        sof;
        logic        tlast;
        logic [23:0] data;
        logic        fwd;
        logic [3:0]  pulses;
    } vec_t;

    vec_t        tbl[$];
    vec_t        cur;
    logic [23:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          data_ctr = 0;
    logic        mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic sof, input logic tlast, input logic fwd, input logic [3:0] pulses);
        vec_t v;
        data_ctr++;
        v.sof    = sof;
        v.tlast  = tlast;
        v.data   = 24'hA00000 + 24'(data_ctr);
        v.fwd    = fwd;
        v.pulses = pulses;
        tbl.push_back(v);
    endtask

    // Monitor: pulses of the beat accepted on the previous edge, output
    // stability under back-pressure, and in-order delivery of forwarded data.
    logic        pend_v;
    vec_t        pend;
    logic        prev_en;
    logic        prev_stall;
    logic [23:0] prev_data;
    logic [3:0]  prev_pulses;
    logic [3:0]  exp_p;
    logic [23:0] exp_d;

    initial begin
        pend_v     = 1'b0;
        prev_en    = 1'b0;
        prev_stall = 1'b0;
    end

    always @(negedge aclk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_axi4s_tvalid), 64'd1);
                check("stall_data", 64'(m_axi4s_tdata), 64'(prev_data));
            end
            if (prev_en) begin
                exp_p = pend_v ? pend.pulses : 4'b0000;
                check("pulses", 64'({frame_start, frame_end, err_sof, err_eol}), 64'(exp_p));
            end else begin
                check("pulses_hold", 64'({frame_start, frame_end, err_sof, err_eol}), 64'(prev_pulses));
            end
            if (aclken && m_axi4s_tvalid && m_axi4s_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(m_axi4s_tdata), 64'hDEAD);
                end else begin
                    exp_d = sb.pop_front();
                    check("data", 64'(m_axi4s_tdata), 64'(exp_d));
                end
            end
            pend_v = aclken && s_axi4s_tvalid && s_axi4s_tready;
            pend   = cur;
            if (pend_v && cur.fwd) sb.push_back(cur.data);
            prev_en     = aclken;
            prev_stall  = m_axi4s_tvalid && !m_axi4s_tready;
            prev_data   = m_axi4s_tdata;
            prev_pulses = {frame_start, frame_end, err_sof, err_eol};
        end else begin
            pend_v     = 1'b0;
            prev_en    = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // Drive every table beat until accepted; stress mode randomises tvalid
    // and toggles m_tready each cycle.
    task automatic run(input bit stress);
        logic acc;
        int   guard;
        for (int i = 0; i < tbl.size(); i++) begin
            cur            = tbl[i];
            s_axi4s_tuser  = cur.sof;
            s_axi4s_tlast  = cur.tlast;
            s_axi4s_tdata  = cur.data;
            guard          = 0;
            do begin
                s_axi4s_tvalid = stress ? (($urandom & 1) != 0) : 1'b1;
                m_axi4s_tready = stress ? ~m_axi4s_tready : 1'b1;
                @(negedge aclk);
                acc = s_axi4s_tvalid && s_axi4s_tready && aclken;
                @(posedge aclk);
                #1;
                guard++;
            end while (!acc && guard < 200);
            if (!acc) check("accept_timeout", 64'(guard), 64'd0);
        end
        s_axi4s_tvalid = 1'b0;
        m_axi4s_tready = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
        tbl.delete();
    endtask

    task automatic std_frame();
        add(1'b1, 1'b0, 1'b1, 4'b1000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn        = 1'b0;
        aclken         = 1'b1;
        param_width    = 10'd4;
        param_height   = 10'd2;
        s_axi4s_tuser  = 1'b0;
        s_axi4s_tlast  = 1'b0;
        s_axi4s_tdata  = '0;
        s_axi4s_tvalid = 1'b0;
        m_axi4s_tready = 1'b1;
        cur            = '{default: '0};

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(m_axi4s_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axi4s_tdata), 64'd0);
        check("rst_pulses", 64'({frame_start, frame_end, err_sof, err_eol}), 64'd0);
        check("rst_tready", 64'(s_axi4s_tready), 64'd1);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        mon_en = 1'b1;

        // 1: pre-SOF garbage dropped, clean 4x2 frame, trailing beats dropped
        add(1'b0, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b0000);
        std_frame();
        add(1'b0, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b1, 1'b0, 4'b0000);
        run(1'b0);

        // 2: same frame under random valid and toggling ready
        std_frame();
        run(1'b1);

        // 3: short line (tlast at x=2), next line starts at x=0,y=1
        add(1'b1, 1'b0, 1'b1, 4'b1000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0001);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0100);
        run(1'b0);

        // 4: long line, flagged once at x=3, line ends at x=5
        add(1'b1, 1'b0, 1'b1, 4'b1000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0001);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0100);
        run(1'b0);

        // 5: SOF mid-frame at line 1, x=2 -> resync, abandoned frame has no end
        add(1'b1, 1'b0, 1'b1, 4'b1000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b1, 1'b0, 1'b1, 4'b1010);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 1'b1, 4'b0100);
        run(1'b0);

        // 6: 1x1 frames back to back, start and end on the same beat
        param_width  = 10'd1;
        param_height = 10'd1;
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, 4'b1100);
        run(1'b0);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, 4'b1100);
        run(1'b1);

        mon_en       = 1'b0;
        param_width  = 10'd4;
        param_height = 10'd2;
        @(posedge aclk);
        #1;

        // Clock enable low: output beat and pulses hold, no new acceptance
        s_axi4s_tuser  = 1'b1;
        s_axi4s_tlast  = 1'b0;
        s_axi4s_tdata  = 24'h123456;
        s_axi4s_tvalid = 1'b1;
        m_axi4s_tready = 1'b1;
        @(posedge aclk);
        #1;
        aclken         = 1'b0;
        s_axi4s_tuser  = 1'b0;
        s_axi4s_tdata  = 24'h654321;
        repeat (3) @(posedge aclk);
        #1;
        check("en_hold_valid", 64'(m_axi4s_tvalid), 64'd1);
        check("en_hold_data", 64'(m_axi4s_tdata), 64'h123456);
        check("en_hold_fs", 64'(frame_start), 64'd1);
        aclken = 1'b1;
        @(posedge aclk);
        #1;
        check("en_resume_data", 64'(m_axi4s_tdata), 64'h654321);
        check("en_resume_fs", 64'(frame_start), 64'd0);

        // Reset mid-frame with a beat stalled on the output
        s_axi4s_tuser  = 1'b0;
        s_axi4s_tdata  = 24'h0000AA;
        m_axi4s_tready = 1'b0;
        @(posedge aclk);
        #1;
        s_axi4s_tvalid = 1'b0;
        check("pre_rst_valid", 64'(m_axi4s_tvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        check("async_rst_valid", 64'(m_axi4s_tvalid), 64'd0);
        @(posedge aclk);
        #1;
        aresetn        = 1'b1;
        m_axi4s_tready = 1'b1;
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tuser  = 1'b0;
        s_axi4s_tdata  = 24'h0000BB;
        @(posedge aclk);
        #1;
        check("post_rst_drop", 64'(m_axi4s_tvalid), 64'd0);
        s_axi4s_tuser = 1'b1;
        s_axi4s_tdata = 24'h0000CC;
        @(posedge aclk);
        #1;
        s_axi4s_tvalid = 1'b0;
        check("resync_valid", 64'(m_axi4s_tvalid), 64'd1);
        check("resync_data", 64'(m_axi4s_tdata), 64'hCC);
        check("resync_pulses", 64'({frame_start, frame_end, err_sof, err_eol}), 64'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
